// File: rtl/nanci_seq_pkg.sv
// nanci_seq_pkg: shared state encoding, axis constants and latency helper for the Nanci sort sequencer.
package nanci_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ROW     = 3'd1,
    S_COL     = 3'd2,
    S_COMPUTE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam logic AXIS_H = 1'b0;
  localparam logic AXIS_V = 1'b1;

  function automatic int default_latency(input int sqrt_n, input int rounds, input int step_cycles,
                                         input int compute_cycles);
    return (2 * rounds - 1) * sqrt_n * step_cycles + compute_cycles + 1;
  endfunction
endpackage

// File: rtl/nanci_step_timer.sv
// nanci_step_timer: loadable down counter giving the step-end tick and a registered first-cycle strobe.
module nanci_step_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic         i_strobe,
  input  logic [W-1:0] i_len,
  output logic         o_tick,
  output logic         o_first
);
  logic [W-1:0] cnt_q, cnt_d;
  logic         first_q, first_d;

  always_comb begin
    cnt_d   = i_clr ? '0 : i_load ? i_len : (cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    first_d = i_load & i_strobe & ~i_clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign o_tick  = cnt_q == '0;
  assign o_first = first_q;
endmodule

// File: rtl/nanci_sort_sequencer.sv
// nanci_sort_sequencer: shearsort step broadcaster for the Nanci PE mesh.
// Optional early exit on two clean phases is enabled by defining NANCI_EARLY_EXIT_EN.
module nanci_sort_sequencer
  import nanci_seq_pkg::*;
#(
  parameter int SQRT_N         = 4,
  parameter int SORT_ROUNDS    = 3,
  parameter int STEP_CYCLES    = 1,
  parameter int COMPUTE_CYCLES = 1,
  parameter int ROUND_W        = (SORT_ROUNDS > 1) ? $clog2(SORT_ROUNDS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_swap,
  output logic               o_busy,
  output logic               o_step_valid,
  output logic               o_axis,
  output logic               o_parity,
  output logic               o_snake,
  output logic [ROUND_W-1:0] o_round,
  output logic               o_compute_en,
  output logic               o_done
);
  localparam int SW   = $clog2(SQRT_N);
  localparam int TMAX = (STEP_CYCLES > COMPUTE_CYCLES) ? STEP_CYCLES : COMPUTE_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_e             state_q, state_d;
  logic [SW-1:0]      step_q, step_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               busy_q, busy_d, axis_q, axis_d, snake_q, snake_d;
  logic               compute_en_q, compute_en_d, done_q, done_d;
  logic               tick, load, strobe, phase_end, early;
  logic [TW-1:0]      len;

  assign phase_end = (state_q == S_ROW || state_q == S_COL) && tick && step_q == SW'(SQRT_N - 1);

`ifdef NANCI_EARLY_EXIT_EN
  logic seen_q, seen_d, clean_q, clean_d;

  // clean_q remembers that the previous completed phase saw no swap at all
  always_comb begin
    seen_d  = (state_q == S_IDLE || phase_end || i_abort) ? 1'b0 : seen_q | i_swap;
    clean_d = (state_q == S_IDLE || i_abort) ? 1'b0 : phase_end ? ~(seen_q | i_swap) : clean_q;
    early   = phase_end & clean_q & ~(seen_q | i_swap);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q  <= 1'b0;
      clean_q <= 1'b0;
    end else begin
      seen_q  <= seen_d;
      clean_q <= clean_d;
    end
  end
`else
  logic unused_swap;
  assign unused_swap = i_swap;
  assign early       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    round_d = round_q;
    load    = 1'b0;
    strobe  = 1'b0;
    done_d  = 1'b0;
    len     = TW'(STEP_CYCLES - 1);
    case (state_q)
      S_IDLE: if (i_start) begin
        state_d = S_ROW;
        step_d  = '0;
        round_d = '0;
        load    = 1'b1;
        strobe  = 1'b1;
      end
      S_ROW, S_COL: if (tick) begin
        load = 1'b1;
        if (!phase_end) begin
          step_d = step_q + SW'(1);
          strobe = 1'b1;
        end else begin
          step_d = '0;
          if (early || (state_q == S_ROW && round_q == ROUND_W'(SORT_ROUNDS - 1))) begin
            state_d = S_COMPUTE;
            len     = TW'(COMPUTE_CYCLES - 1);
          end else begin
            state_d = (state_q == S_ROW) ? S_COL : S_ROW;
            round_d = (state_q == S_COL) ? round_q + ROUND_W'(1) : round_q;
            strobe  = 1'b1;
          end
        end
      end
      S_COMPUTE: if (tick) begin
        state_d = S_DONE;
        round_d = '0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_abort) begin
      state_d = S_IDLE;
      step_d  = '0;
      round_d = '0;
      load    = 1'b0;
      strobe  = 1'b0;
      done_d  = 1'b0;
    end
    busy_d       = state_d == S_ROW || state_d == S_COL || state_d == S_COMPUTE;
    axis_d       = (state_d == S_COL) ? AXIS_V : AXIS_H;
    snake_d      = state_d == S_ROW;
    compute_en_d = state_d == S_COMPUTE;
  end

  nanci_step_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (i_abort),
    .i_load  (load),
    .i_strobe(strobe),
    .i_len   (len),
    .o_tick  (tick),
    .o_first (o_step_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      round_q      <= '0;
      busy_q       <= 1'b0;
      axis_q       <= 1'b0;
      snake_q      <= 1'b0;
      compute_en_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      round_q      <= round_d;
      busy_q       <= busy_d;
      axis_q       <= axis_d;
      snake_q      <= snake_d;
      compute_en_q <= compute_en_d;
      done_q       <= done_d;
    end
  end

  assign o_busy       = busy_q;
  assign o_axis       = axis_q;
  assign o_parity     = step_q[0];
  assign o_snake      = snake_q;
  assign o_round      = round_q;
  assign o_compute_en = compute_en_q;
  assign o_done       = done_q;
endmodule

// File: tb/tb_nanci_sort_sequencer.sv
// tb_nanci_sort_sequencer: directed bench for the sort sequencer, STEP_CYCLES=1 and STEP_CYCLES=3 side by side.
module tb_nanci_sort_sequencer;
  logic clk = 1'b0;
  logic rst, i_start, i_abort, i_swap;
  logic busy_a, sv_a, axis_a, par_a, snake_a, ce_a, done_a;
  logic busy_b, sv_b, axis_b, par_b, snake_b, ce_b, done_b;
  logic [1:0] rnd_a, rnd_b;
  logic [8:0] va, vb;
  int n_cmp = 0, n_err = 0;
  int lat, dones, first;
  logic [1:0] crnd;

  always #5 clk = ~clk;

  nanci_sort_sequencer #(.SQRT_N(4), .SORT_ROUNDS(3), .STEP_CYCLES(1), .COMPUTE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_swap(i_swap),
    .o_busy(busy_a), .o_step_valid(sv_a), .o_axis(axis_a), .o_parity(par_a), .o_snake(snake_a),
    .o_round(rnd_a), .o_compute_en(ce_a), .o_done(done_a)
  );

  nanci_sort_sequencer #(.SQRT_N(4), .SORT_ROUNDS(3), .STEP_CYCLES(3), .COMPUTE_CYCLES(1)) dut3 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_swap(i_swap),
    .o_busy(busy_b), .o_step_valid(sv_b), .o_axis(axis_b), .o_parity(par_b), .o_snake(snake_b),
    .o_round(rnd_b), .o_compute_en(ce_b), .o_done(done_b)
  );

  assign va = {busy_a, sv_a, axis_a, par_a, snake_a, rnd_a, ce_a, done_a};
  assign vb = {busy_b, sv_b, axis_b, par_b, snake_b, rnd_b, ce_b, done_b};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {busy,step_valid,axis,parity,snake,round,compute_en,done} in cycle c after the start edge.
  function automatic logic [8:0] exp_vec(input int c, input int sc);
    int idx, st, p;
    logic b, v, a, pa, sn, ce, d;
    logic [1:0] r;
    {b, v, a, pa, sn, ce, d} = '0;
    r = '0;
    if (c >= 1 && c <= 20 * sc) begin
      idx = c - 1;
      st  = idx / sc;
      p   = st / 4;
      b   = 1'b1;
      v   = (idx % sc) == 0;
      a   = (p % 2) == 1;
      pa  = (st % 2) == 1;
      sn  = !a;
      r   = 2'(p / 2);
    end else if (c == 20 * sc + 1) begin
      b  = 1'b1;
      ce = 1'b1;
      r  = 2'd2;
    end else if (c == 20 * sc + 2) begin
      d = 1'b1;
    end
    return {b, v, a, pa, sn, r, ce, d};
  endfunction

  task automatic run_lat(output int l, output logic [1:0] r);
    l = -1;
    r = '1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (ce_a) r = rnd_a;
      if (done_a) begin
        l = c;
        break;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_swap = 1'b1;
    repeat (2) tick();
    chk("reset_a", va, 0);
    chk("reset_b", vb, 0);
    rst = 1'b0;
    tick();

    i_start = 1'b1; i_abort = 1'b1;
    tick();
    chk("abort_beats_start", va, 0);
    i_start = 1'b0; i_abort = 1'b0;
    tick();

    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= 63; c++) begin
      chk($sformatf("sched1_c%0d", c), va, exp_vec(c, 1));
      chk($sformatf("sched3_c%0d", c), vb, exp_vec(c, 3));
      tick();
    end

    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (13) tick();
    chk("pre_abort_col_r1", va, exp_vec(14, 1));
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_clear_a", va, 0);
    chk("abort_clear_b", vb, 0);
    dones = 0;
    repeat (30) begin
      tick();
      if (done_a) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_lat(lat, crnd);
    chk("restart_latency", lat, 22);
    tick();

    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    dones = 0;
    first = -1;
    for (int c = 1; c <= 40; c++) begin
      if (done_a) begin
        dones++;
        if (first < 0) first = c;
      end
      i_start = (c == 5 || c == 21);
      tick();
    end
    i_start = 1'b0;
    chk("repulse_one_done", dones, 1);
    chk("repulse_latency", first, 22);

    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (2) tick();
    chk("pre_rst_busy", busy_a, 1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_a", va, 0);
    chk("async_rst_b", vb, 0);
    #1 rst = 1'b0;
    repeat (5) tick();
    chk("no_resume_a", va, 0);
    chk("no_resume_b", vb, 0);

    i_swap = 1'b0;
    run_lat(lat, crnd);
`ifdef NANCI_EARLY_EXIT_EN
    chk("noswap_latency", lat, 10);
    chk("noswap_round", crnd, 0);
`else
    chk("noswap_latency", lat, 22);
    chk("noswap_round", crnd, 2);
`endif
    i_swap = 1'b1;
    tick();
    run_lat(lat, crnd);
    chk("swap_latency", lat, 22);
    chk("swap_round", crnd, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/nanci_sort_sequencer.md
Name: nanci_sort_sequencer

Overview:
- Global controller for the Nanci PE mesh: broadcasts shearsort step commands to every PE in a SQRT_N x SQRT_N array.
- Sequences alternating row phases (snake order) and column phases, each made of SQRT_N odd-even transposition steps, then one compute window.
- Sits above the PE array; each PE decodes axis/parity/snake to pick its l/r or u/d neighbour and its compare direction.

Parameters:
- SQRT_N, 4, mesh side length; steps per phase; must be >= 2.
- SORT_ROUNDS, 3, number of row phases; column phases = SORT_ROUNDS-1; must be >= 1.
- STEP_CYCLES, 1, cycles each step command is held; must be >= 1.
- COMPUTE_CYCLES, 1, length of compute window; must be >= 1.
- ROUND_W, $clog2(SORT_ROUNDS) (minimum 1), width of o_round.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_start  in  1  start request, sampled only in IDLE
- i_abort  in  1  forces IDLE on next edge; beats i_start
- i_swap  in  1  OR of all PE swap flags for the current step; used only with the optional feature
- o_busy  out  1  high in ROW/COL/COMPUTE
- o_step_valid  out  1  one-cycle strobe on the first cycle of each step
- o_axis  out  1  0 = horizontal (l/r), 1 = vertical (u/d)
- o_parity  out  1  step index bit 0; 0 = pairs (even, odd), 1 = pairs (odd, even)
- o_snake  out  1  1 in ROW (odd rows descending), 0 otherwise
- o_round  out  ROUND_W  current row-phase index
- o_compute_en  out  1  high throughout the compute window
- o_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: asynchronous and active-high. All outputs 0, state IDLE, all counters 0.
- States: IDLE, ROW, COL, COMPUTE, DONE. All outputs are registered.
- IDLE -> ROW: on an edge where i_start=1 and i_abort=0. o_step_valid is high in the next cycle with round=0, step=0.
- Step timing:
  - A step lasts STEP_CYCLES cycles; o_step_valid is high only in its first cycle.
  - The step counter runs 0..SQRT_N-1.
  - o_parity = step[0], held stable for the whole step.
- ROW, last step ends:
  - if round < SORT_ROUNDS-1: go to COL;
  - else go to COMPUTE.
- COL, last step ends: round increments, go to ROW. o_axis=1 and o_snake=0 throughout COL.
- COMPUTE: COMPUTE_CYCLES cycles with o_compute_en=1, then DONE.
- DONE: o_done=1 for one cycle, o_busy=0, then IDLE.
- Latency, start edge to o_done cycle: (2*SORT_ROUNDS-1)*SQRT_N*STEP_CYCLES + COMPUTE_CYCLES + 1. Defaults give 22 cycles.
- i_start while busy: ignored, no queueing.
- i_abort in any state: next state IDLE, outputs cleared, no o_done.
- Asynchronous reset mid-operation: immediate return to the reset values.
- SORT_ROUNDS=1: ROW -> COMPUTE directly; COL never occurs.

Optional Feature:
- Macro: NANCI_EARLY_EXIT_EN.
- With the macro:
  - a sticky swap_seen flag is cleared at the start of each phase and set by i_swap=1 in any cycle of the phase;
  - if two consecutive completed phases both end with swap_seen=0, go directly to COMPUTE, skipping all remaining phases;
  - o_round holds its last value during the skip.
- Without the macro: i_swap is ignored and the full schedule always runs.

Decomposition:
- Package nanci_seq_pkg:
  - state encoding (IDLE=0, ROW=1, COL=2, COMPUTE=3, DONE=4);
  - axis constants AXIS_H=0, AXIS_V=1;
  - a function computing the default latency for benches.
- One sub-module, nanci_step_timer: a loadable down counter that generates the step-end tick and the first-cycle strobe. It is reused for step and compute timing.

Test Plan:
- Defaults, one i_start pulse -> 4 ROW steps (parity 0,1,0,1, axis 0, snake 1), 4 COL steps (axis 1), repeated; round 0,0,1,1,2; compute for 1 cycle; o_done exactly 22 cycles after the start edge.
- STEP_CYCLES=3 -> each o_step_valid is followed by 2 idle-strobe cycles with axis/parity held; o_done at cycle 62.
- i_abort during COL of round 1 -> IDLE next cycle, all outputs 0, no o_done; a fresh i_start then completes in 22 cycles.
- i_start re-pulsed at cycles 5 and 21 -> ignored; exactly one o_done.
- rst asserted mid-ROW, asynchronously between edges -> outputs drop to 0 immediately; resumes only on a new i_start.
- NANCI_EARLY_EXIT_EN with i_swap=0 always -> COMPUTE after the first COL phase ends; o_done 10 cycles after start. With i_swap=1 every step -> 22 cycles.
